// File: rtl/niosii_subsys_nios2_gen2_0_cpu_mul_combine.sv
// Two-stage combiner for the three 16x16 partial products of the Nios II multiplier.
// Produces the low 32 bits of src1*src2 and its register tag, with valid/ready backpressure and flush.
module niosii_subsys_nios2_gen2_0_cpu_mul_combine #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      M_mul_cell_p1,
    input  logic [31:0]      M_mul_cell_p2,
    input  logic [31:0]      M_mul_cell_p3,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic             r_s1_valid;
    logic [31:0]      r_s1_lo;
    logic [15:0]      r_s1_cross;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [31:0]      r_s2_result;
    logic [TAG_W-1:0] r_s2_tag;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_s1_load;
    logic             w_s2_load;
    logic [15:0]      w_cross;
    logic [15:0]      w_hi;

    assign w_s2_adv  = ~r_s2_valid | out_ready;
    assign w_s1_adv  = ~r_s1_valid | w_s2_adv;
    assign w_s1_load = in_valid & w_s1_adv;
    assign w_s2_load = r_s1_valid & w_s2_adv;

    // Upper halves of the cross products only reach bits >= 32, so they are dropped here.
    assign w_cross = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
    assign w_hi    = r_s1_lo[31:16] + r_s1_cross;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_lo    <= '0;
            r_s1_cross <= '0;
            r_s1_tag   <= '0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_adv) begin
                r_s1_valid <= in_valid;
            end
            if (w_s1_load) begin
                r_s1_lo    <= M_mul_cell_p1;
                r_s1_cross <= w_cross;
                r_s1_tag   <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_tag    <= '0;
        end else begin
            if (flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_load) begin
                r_s2_result <= {w_hi, r_s1_lo[15:0]};
                r_s2_tag    <= r_s1_tag;
            end
        end
    end

    assign in_ready   = w_s1_adv;
    assign out_valid  = r_s2_valid;
    assign out_result = r_s2_result;
    assign out_tag    = r_s2_tag;
    assign busy       = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_niosii_subsys_nios2_gen2_0_cpu_mul_combine.sv
// Scoreboard bench for the multiplier partial-product combiner.
module tb_niosii_subsys_nios2_gen2_0_cpu_mul_combine;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [31:0]      p1, p2, p3;
    logic             in_valid;
    logic [TAG_W-1:0] in_tag;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    typedef logic [TAG_W+31:0] ent_t;
    ent_t sb[$];
    ent_t cur_exp;
    int   n_total = 0;
    int   n_bad   = 0;
    int   n_out   = 0;

    always #5 clk = ~clk;

    niosii_subsys_nios2_gen2_0_cpu_mul_combine #(.TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .M_mul_cell_p1(p1), .M_mul_cell_p2(p2), .M_mul_cell_p3(p3),
        .in_valid(in_valid), .in_tag(in_tag), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lo_prod(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'h0, a} * {32'h0, b};
        return full[31:0];
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
        p1 = {16'h0, a[15:0]}  * {16'h0, b[15:0]};
        p2 = {16'h0, a[15:0]}  * {16'h0, b[31:16]};
        p3 = {16'h0, a[31:16]} * {16'h0, b[15:0]};
        in_tag   = tag;
        in_valid = 1'b1;
        cur_exp  = {tag, lo_prod(a, b)};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the product on the inputs until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
        logic acc;
        logic done;
        done = 1'b0;
        drive(a, b, tag);
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) done = 1'b1;
        end
        if (!done) chk("send_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    // Transfers are decided on the coming rising edge; inputs are stable at the falling edge.
    always @(negedge clk) begin
        ent_t e;
        if (reset_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_result", out_result, e[31:0]);
                    chk("sb_tag", out_tag, e[TAG_W+31:32]);
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        logic [31:0] exp_a;
        logic [31:0] exp_m;

        reset_n = 1'b0; in_valid = 1'b0; in_tag = '0; flush = 1'b0; out_ready = 1'b0;
        p1 = '0; p2 = '0; p3 = '0; cur_exp = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // small known product and latency
        out_ready = 1'b1;
        send(32'h0003_0002, 32'h0005_0004, 5'd7);
        chk("lat_s1_only", out_valid, 0);
        chk("lat_busy", busy, 1);
        tick();
        chk("lat_out_valid", out_valid, 1);
        chk("small_result", out_result, 32'h0016_0008);
        chk("small_tag", out_tag, 7);

        // wrap of cross term and upper half
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        tick();
        chk("wrap_result", out_result, 32'h0000_0001);
        chk("wrap_tag", out_tag, 3);
        tick();

        // back-to-back stream
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            drive($urandom, $urandom, 5'(i + 8));
            @(negedge clk);
            chk("stream_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("stream_count", n_out - base, 8);

        // fill, hold while stalled, then release with a same-cycle accept
        base = n_out;
        out_ready = 1'b0;
        exp_a = lo_prod(32'h1234_5678, 32'h9ABC_DEF0);
        send(32'h1234_5678, 32'h9ABC_DEF0, 5'd20);
        send(32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd21);
        drive(32'h0000_FFFF, 32'hFFFF_0000, 5'd22);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_in_ready", in_ready, 0);
            chk("full_out_valid", out_valid, 1);
            chk("full_result", out_result, exp_a);
            chk("full_tag", out_tag, 20);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        tick();
        drive(32'h8000_0001, 32'h7FFF_FFFF, 5'd23);
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("release_count", n_out - base, 4);

        // flush with both stages full and input pending
        base = n_out;
        out_ready = 1'b0;
        send(32'h0000_0011, 32'h0000_0022, 5'd1);
        send(32'h0000_0033, 32'h0000_0044, 5'd2);
        drive(32'h0000_0055, 32'h0000_0066, 5'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("flush_count", n_out - base, 0);

        // flush while an output is taken and an input would be accepted
        base = n_out;
        drive(32'h0001_0001, 32'h0002_0002, 5'd4); tick();
        drive(32'h0003_0003, 32'h0004_0004, 5'd5); tick();
        drive(32'h0005_0005, 32'h0006_0006, 5'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2_out_valid", out_valid, 0);
        chk("flush2_busy", busy, 0);
        tick(); tick(); tick();
        chk("flush2_count", n_out - base, 1);

        // reset mid-stream
        drive(32'h0000_0101, 32'h0000_0202, 5'd10); tick();
        drive(32'h0000_0303, 32'h0000_0404, 5'd11); tick();
        reset_n = 1'b0; in_valid = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_result", out_result, 0);
        chk("mid_rst_out_tag", out_tag, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        tick();
        reset_n = 1'b1;
        base = n_out;
        exp_m = lo_prod(32'hCAFE_1234, 32'h5678_BEEF);
        send(32'hCAFE_1234, 32'h5678_BEEF, 5'd9);
        tick();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_result", out_result, exp_m);
        chk("post_rst_tag", out_tag, 9);
        tick(); tick();
        chk("post_rst_count", n_out - base, 1);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/niosii_subsys_nios2_gen2_0_cpu_mul_combine.md
# niosii_subsys_nios2_gen2_0_cpu_mul_combine

Pipelined partial-product combiner for the Nios II gen2 CPU multiplier path. It sits directly downstream of the three-DSP mult cell. It consumes the registered 16x16 partial products lo*lo, lo*hi and hi*lo, and produces the low 32 bits of the 32x32 product together with the destination register tag. Two register stages with a valid/ready handshake give backpressure and pipeline-flush support; `in_ready` drives the mult cell's stage enable.

## Interface
- `TAG_W`, default 5: width of the destination register tag carried alongside each product.
- `clk`  in  1: CPU clock; all state changes on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `M_mul_cell_p1`  in  32: unsigned src1[15:0]*src2[15:0].
- `M_mul_cell_p2`  in  32: unsigned src1[15:0]*src2[31:16].
- `M_mul_cell_p3`  in  32: unsigned src1[31:16]*src2[15:0].
- `in_valid`  in  1: partial products and tag are valid this cycle.
- `in_tag`  in  TAG_W: destination register number for this product.
- `in_ready`  out  1: stage 1 accepts this cycle. Also used upstream as the mult cell `M_en`.
- `flush`  in  1: synchronous kill of all in-flight products.
- `out_valid`  out  1: `out_result` and `out_tag` are valid.
- `out_ready`  in  1: consumer takes the output this cycle.
- `out_result`  out  32: low 32 bits of src1*src2.
- `out_tag`  out  TAG_W: tag of `out_result`.
- `busy`  out  1: either stage holds a valid entry.

## Operation
- Stage 1 (S1) register fields:
  - `s1_valid`
  - `s1_lo` = p1 (32 bits)
  - `s1_cross` = (p2[15:0] + p3[15:0]) mod 2^16
  - `s1_tag`
- p2[31:16] and p3[31:16] are ignored; they only affect bits ≥32.
- Stage 2 (S2) register fields:
  - `s2_valid`
  - `s2_result` = {(s1_lo[31:16] + s1_cross) mod 2^16, s1_lo[15:0]}
  - `s2_tag`
- All arithmetic is unsigned and modulo its field width. No carry leaves bit 31.
- Outputs: `out_valid`=`s2_valid`, `out_result`=`s2_result`, `out_tag`=`s2_tag`.
- Handshake equations:
  - s2_adv = ~s2_valid | out_ready
  - s1_adv = ~s1_valid | s2_adv
  - `in_ready` = s1_adv (combinational; no path from `in_valid` to `in_ready`).
- Accept: on `in_valid & in_ready`, S1 loads. On `s1_valid & s2_adv`, S2 loads from S1.
- Hold: a stage whose downstream is not advancing keeps all of its fields unchanged.
- Per-stage valid:
  - S1 next: if s1_adv, `s1_valid` ← `in_valid`; otherwise it holds.
  - S2 next: if s2_adv, `s2_valid` ← `s1_valid`; otherwise it holds.
- Flush: `flush`=1 clears `s1_valid` and `s2_valid` next cycle.
  - Flush overrides any same-cycle accept and any same-cycle output transfer into the register state.
  - An output consumed in the flush cycle (`out_valid & out_ready`) still counts as delivered.
- `busy` = `s1_valid | s2_valid`.
- Data fields of an invalid stage are don't-care, but must update only on advance (no toggling while idle-held).

## Timing
- Reset (asynchronous assert, synchronous release): `s1_valid`=`s2_valid`=0, all data and tag registers 0.
  - Hence `out_valid`=0, `out_result`=0, `out_tag`=0, `busy`=0, `in_ready`=1.
- Latency: product accepted at edge N appears on `out_valid`/`out_result` after edge N+1, i.e. 2 cycles from the mult cell output.
- Throughput: 1 product/cycle with `out_ready` held high.
- Full: both stages valid and `out_ready`=0 → `in_ready`=0. Both stages hold until `out_ready` returns.
  - `out_ready` rising in that state raises `in_ready` in the same cycle.
- Empty: `in_ready`=1 and `out_valid`=0.
- Simultaneous: output taken and new input accepted in the same cycle when full → both stages shift, no bubble, no loss.
- Reset mid-operation: in-flight entries are discarded immediately. No output from them ever appears.

## Test plan
- src1=0x00030002, src2=0x00050004 (p1=0x8, p2=0xA, p3=0xC), `out_ready`=1 → two cycles later `out_valid`=1, `out_result`=0x00160008, tag preserved.
- src1=src2=0xFFFFFFFF (p1=p2=p3=0xFFFE0001) → `out_result`=0x00000001. Checks mod-2^16 wrap of cross term and upper half.
- Back-to-back stream of 8 products with distinct tags, `out_ready`=1 → 8 consecutive `out_valid` cycles, in order, `in_ready` never low.
- Sequence:
  - Fill both stages with `out_ready`=0 → `in_ready`=0, outputs stable 5 cycles.
  - Then raise `out_ready` while driving `in_valid` → same-cycle shift, no drop or duplicate.
- `flush` with both stages valid and `in_valid`=1 → next cycle `out_valid`=0, `busy`=0. The flush-cycle input never emerges.
- Assert `reset_n`=0 mid-stream for 1 cycle → all outputs 0 immediately, `in_ready`=1. The next accepted product emerges after 2 cycles.
